// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART ALU command path.
package uart_alu_pkg;

    localparam logic [7:0] OPC_ECHO = 8'hEC;
    localparam logic [7:0] OPC_ADD  = 8'h01;
    localparam logic [7:0] OPC_MUL  = 8'h02;
    localparam logic [7:0] OPC_DIV  = 8'h03;

    localparam int HDR_BYTES = 4;

    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_MUL,
        ALU_DIV
    } alu_op_e;

    typedef enum logic [3:0] {
        HDR_OP,
        HDR_RSV,
        HDR_LEN_L,
        HDR_LEN_H,
        ECHO,
        ALU,
        DRAIN,
        WAIT_RES,
        SEND_RES
    } frame_state_e;

endpackage

// File: rtl/word_to_bytes_ser.sv
// Loads a 32-bit word and emits it as four AXI-stream bytes, least significant first.
module word_to_bytes_ser (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        load_i,
    input  logic [31:0] word_i,
    output logic [7:0]  m_tdata_o,
    output logic        m_tvalid_o,
    input  logic        m_tready_i,
    output logic        m_last_o
);

    logic [31:0] word_p0;
    logic [1:0]  cnt_q;
    logic        busy_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else if (load_i) begin
            busy_q <= 1'b1;
            cnt_q  <= 2'd0;
        end else if (busy_q && m_tready_i) begin
            busy_q <= (cnt_q != 2'd3);
            cnt_q  <= cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (load_i) begin
            word_p0 <= word_i;
        end else if (busy_q && m_tready_i) begin
            word_p0 <= {8'h00, word_p0[31:8]};
        end
    end

    assign m_tdata_o  = word_p0[7:0];
    assign m_tvalid_o = busy_q;
    assign m_last_o   = (cnt_q == 2'd3);

endmodule

// File: rtl/uart_alu_frame_handler.sv
// Frame parser between uart_rx/uart_tx and the ALU core: echo, operand assembly,
// LSB-first result return and draining of unknown opcodes.
module uart_alu_frame_handler
    import uart_alu_pkg::*;
#(
    parameter int         LEN_W   = 16,
    parameter logic [7:0] ECHO_OP = OPC_ECHO,
    parameter logic [7:0] ADD_OP  = OPC_ADD,
    parameter logic [7:0] MUL_OP  = OPC_MUL,
    parameter logic [7:0] DIV_OP  = OPC_DIV
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [7:0]  s_rx_tdata_i,
    input  logic        s_rx_tvalid_i,
    output logic        s_rx_tready_o,
    output logic [7:0]  m_tx_tdata_o,
    output logic        m_tx_tvalid_o,
    input  logic        m_tx_tready_i,
    output logic [31:0] op_data_o,
    output alu_op_e     op_code_o,
    output logic        op_first_o,
    output logic        op_last_o,
    output logic        op_valid_o,
    input  logic        op_ready_i,
    input  logic [31:0] res_data_i,
    input  logic        res_valid_i,
    output logic        res_ready_o
);

    frame_state_e     state_q, state_d;
    logic [7:0]       opcode_p0, len_l_p0;
    logic [LEN_W-1:0] rem_q, len_rem;
    logic [1:0]       idx_q;
    logic [23:0]      shreg_p0;
    logic [31:0]      op_data_p1;
    alu_op_e          op_code_p0;
    logic             op_first_p1, op_last_p1;
    logic             vld_p1, first_q, sent_q;
    logic             rx_fire;
    logic             ser_load, ser_tvalid, ser_tready, ser_last;
    logic [31:0]      ser_word;
    logic [7:0]       ser_tdata;

    function automatic logic is_alu_op(input logic [7:0] opc);
        return (opc == ADD_OP) || (opc == MUL_OP) || (opc == DIV_OP);
    endfunction

    function automatic alu_op_e to_alu_op(input logic [7:0] opc);
        if (opc == MUL_OP) return ALU_MUL;
        if (opc == DIV_OP) return ALU_DIV;
        return ALU_ADD;
    endfunction

    // Payload bytes left after the header; short lengths collapse to an empty payload.
    function automatic logic [LEN_W-1:0] payload_len(input logic [LEN_W-1:0] len);
        if (len < LEN_W'(HDR_BYTES)) return '0;
        return len - LEN_W'(HDR_BYTES);
    endfunction

    assign rx_fire = s_rx_tvalid_i && s_rx_tready_o;
    assign len_rem = payload_len(LEN_W'({s_rx_tdata_i, len_l_p0}));

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= HDR_OP;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        s_rx_tready_o = 1'b0;
        m_tx_tvalid_o = 1'b0;
        m_tx_tdata_o  = ser_tdata;
        res_ready_o   = 1'b0;
        ser_load      = 1'b0;
        ser_word      = 32'h0;
        ser_tready    = 1'b0;
        case (state_q)
            HDR_OP: begin
                s_rx_tready_o = 1'b1;
                if (rx_fire) state_d = HDR_RSV;
            end
            HDR_RSV: begin
                s_rx_tready_o = 1'b1;
                if (rx_fire) state_d = HDR_LEN_L;
            end
            HDR_LEN_L: begin
                s_rx_tready_o = 1'b1;
                if (rx_fire) state_d = HDR_LEN_H;
            end
            HDR_LEN_H: begin
                s_rx_tready_o = 1'b1;
                if (rx_fire) begin
                    if (opcode_p0 == ECHO_OP) begin
                        state_d = (len_rem == '0) ? HDR_OP : ECHO;
                    end else if (is_alu_op(opcode_p0)) begin
                        if (len_rem == '0) begin
                            state_d  = SEND_RES;
                            ser_load = 1'b1;
                        end else begin
                            state_d = ALU;
                        end
                    end else begin
                        state_d = (len_rem == '0) ? HDR_OP : DRAIN;
                    end
                end
            end
            ECHO: begin
                s_rx_tready_o = m_tx_tready_i;
                m_tx_tvalid_o = s_rx_tvalid_i;
                m_tx_tdata_o  = s_rx_tdata_i;
                if (rx_fire && rem_q == LEN_W'(1)) state_d = HDR_OP;
            end
            DRAIN: begin
                s_rx_tready_o = 1'b1;
                if (rx_fire && rem_q == LEN_W'(1)) state_d = HDR_OP;
            end
            ALU: begin
                s_rx_tready_o = !vld_p1;
                if (vld_p1) begin
                    if (op_ready_i && rem_q == '0) state_d = WAIT_RES;
                end else if (rx_fire && rem_q == LEN_W'(1) && idx_q != 2'd3) begin
                    // Last byte is a discarded trailer; an operand-less frame answers zero.
                    if (sent_q) begin
                        state_d = WAIT_RES;
                    end else begin
                        state_d  = SEND_RES;
                        ser_load = 1'b1;
                    end
                end
            end
            WAIT_RES: begin
                res_ready_o = 1'b1;
                if (res_valid_i) begin
                    state_d  = SEND_RES;
                    ser_load = 1'b1;
                    ser_word = res_data_i;
                end
            end
            SEND_RES: begin
                m_tx_tvalid_o = ser_tvalid;
                ser_tready    = m_tx_tready_i;
                if (ser_tvalid && m_tx_tready_i && ser_last) state_d = HDR_OP;
            end
            default: state_d = HDR_OP;
        endcase
        if (reset_i) begin
            s_rx_tready_o = 1'b0;
            res_ready_o   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rem_q   <= '0;
            idx_q   <= 2'd0;
            vld_p1  <= 1'b0;
            first_q <= 1'b0;
            sent_q  <= 1'b0;
        end else begin
            case (state_q)
                HDR_LEN_H: begin
                    if (rx_fire) begin
                        rem_q   <= len_rem;
                        idx_q   <= 2'd0;
                        first_q <= 1'b1;
                        sent_q  <= 1'b0;
                    end
                end
                ECHO, DRAIN: begin
                    if (rx_fire) rem_q <= rem_q - LEN_W'(1);
                end
                ALU: begin
                    if (vld_p1) begin
                        if (op_ready_i) vld_p1 <= 1'b0;
                    end else if (rx_fire) begin
                        rem_q <= rem_q - LEN_W'(1);
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            vld_p1  <= 1'b1;
                            first_q <= 1'b0;
                            sent_q  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p0: header capture and byte shift-in; stage p1: registered operand.
    always_ff @(posedge clk_i) begin
        if (rx_fire) begin
            case (state_q)
                HDR_OP:    opcode_p0 <= s_rx_tdata_i;
                HDR_LEN_L: len_l_p0  <= s_rx_tdata_i;
                HDR_LEN_H: op_code_p0 <= to_alu_op(opcode_p0);
                ALU: begin
                    shreg_p0 <= {s_rx_tdata_i, shreg_p0[23:8]};
                    if (idx_q == 2'd3) begin
                        op_data_p1  <= {s_rx_tdata_i, shreg_p0};
                        op_first_p1 <= first_q;
                        op_last_p1  <= (rem_q - LEN_W'(1)) < LEN_W'(HDR_BYTES);
                    end
                end
                default: ;
            endcase
        end
    end

    assign op_data_o  = op_data_p1;
    assign op_code_o  = op_code_p0;
    assign op_first_o = op_first_p1;
    assign op_last_o  = op_last_p1;
    assign op_valid_o = vld_p1;

    word_to_bytes_ser u_ser (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (ser_load),
        .word_i     (ser_word),
        .m_tdata_o  (ser_tdata),
        .m_tvalid_o (ser_tvalid),
        .m_tready_i (ser_tready),
        .m_last_o   (ser_last)
    );

endmodule
